// File: rtl/dds_pkg.sv
// Shared constants and FSM state type for the three-phase sine DDS sequencer.
package dds_pkg;
    localparam int PHASE_W  = 32;
    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 16;
    localparam int OFF_120  = 10923;
    localparam int OFF_240  = 21845;
    localparam int LUT_LAT  = 1;
    localparam int DRAIN_CW = $clog2(LUT_LAT + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/sine_phase_sequencer_if.sv
// Configuration handshake bundle: tuning word and global phase offered with valid/ready.
interface sine_phase_sequencer_if;
    logic                          cfg_valid;
    logic                          cfg_ready;
    logic [dds_pkg::PHASE_W-1:0]   cfg_ftw;
    logic [dds_pkg::ADDR_W-1:0]    cfg_phase;

    modport master (output cfg_valid, output cfg_ftw, output cfg_phase, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ftw, input cfg_phase, output cfg_ready);
endinterface

// File: rtl/sine_phase_sequencer_phase_offset_gen.sv
// Combinational table-address generator: phase-shifted base plus 120/240 degree offsets.
module phase_offset_gen
    import dds_pkg::*;
(
    input  logic [ADDR_W-1:0] acc_top,
    input  logic [ADDR_W-1:0] phase,
    output logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] addr2,
    output logic [ADDR_W-1:0] addr3
);
    logic [ADDR_W-1:0] base;

    assign base  = acc_top + phase;
    assign addr1 = base;
    assign addr2 = base + ADDR_W'(OFF_120);
    assign addr3 = base + ADDR_W'(OFF_240);
endmodule

// File: rtl/sine_phase_sequencer.sv
// Three-phase DDS controller: phase accumulator, run/drain FSM, wrap-synchronous
// configuration update and re-alignment of the returned table data.
module sine_phase_sequencer
    import dds_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   sample_tick,
    sine_phase_sequencer_if.slave  cfg,
    output logic [ADDR_W-1:0]      address1,
    output logic [ADDR_W-1:0]      address2,
    output logic [ADDR_W-1:0]      address3,
    input  logic [DATA_W-1:0]      lut_data1,
    input  logic [DATA_W-1:0]      lut_data2,
    input  logic [DATA_W-1:0]      lut_data3,
    output logic [DATA_W-1:0]      sample1,
    output logic [DATA_W-1:0]      sample2,
    output logic [DATA_W-1:0]      sample3,
    output logic                   sample_valid,
    output logic                   wrap,
    output logic                   busy
);
    state_t                state_q, state_d;
    logic [PHASE_W-1:0]    acc_q, acc_d, ftw_q, ftw_d, pend_ftw_q, pend_ftw_d;
    logic [ADDR_W-1:0]     phase_q, phase_d, pend_phase_q, pend_phase_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [DRAIN_CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [LUT_LAT:0]      tick_pipe_q, tick_pipe_d;
    logic [ADDR_W-1:0]     addr1_q, addr1_d, addr2_q, addr2_d, addr3_q, addr3_d;
    logic [DATA_W-1:0]     smp1_q, smp1_d, smp2_q, smp2_d, smp3_q, smp3_d;
    logic                  sample_valid_q, sample_valid_d, wrap_q, wrap_d;
    logic                  cfg_accept, adv, carry;
    logic [PHASE_W-1:0]    acc_sum;
    logic [ADDR_W-1:0]     gen_a1, gen_a2, gen_a3;

    // One pending slot in RUN; the handshake stalls until the slot drains at wrap.
    assign cfg.cfg_ready = (state_q == IDLE) || ((state_q == RUN) && !pend_valid_q);
    assign cfg_accept    = cfg.cfg_valid && cfg.cfg_ready;
    assign adv           = (state_q == RUN) && sample_tick;
    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, ftw_q};

    phase_offset_gen u_offset (
        .acc_top (acc_sum[PHASE_W-1 -: ADDR_W]),
        .phase   (phase_q),
        .addr1   (gen_a1),
        .addr2   (gen_a2),
        .addr3   (gen_a3)
    );

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        ftw_d          = ftw_q;
        phase_d        = phase_q;
        pend_ftw_d     = pend_ftw_q;
        pend_phase_d   = pend_phase_q;
        pend_valid_d   = pend_valid_q;
        drain_cnt_d    = drain_cnt_q;
        wrap_d         = 1'b0;
        addr1_d        = addr1_q;
        addr2_d        = addr2_q;
        addr3_d        = addr3_q;

        if (adv) begin
            acc_d   = acc_sum;
            wrap_d  = carry;
            addr1_d = gen_a1;
            addr2_d = gen_a2;
            addr3_d = gen_a3;
        end

        case (state_q)
            IDLE: begin
                if (cfg_accept) begin
                    ftw_d   = cfg.cfg_ftw;
                    phase_d = cfg.cfg_phase;
                end
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (adv && carry && pend_valid_q) begin
                    ftw_d        = pend_ftw_q;
                    phase_d      = pend_phase_q;
                    pend_valid_d = 1'b0;
                end
                if (cfg_accept) begin
                    pend_ftw_d   = cfg.cfg_ftw;
                    pend_phase_d = cfg.cfg_phase;
                    pend_valid_d = 1'b1;
                end
                if (!enable) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_CW'(LUT_LAT)) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    if (pend_valid_q) begin
                        ftw_d        = pend_ftw_q;
                        phase_d      = pend_phase_q;
                        pend_valid_d = 1'b0;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Tick travels alongside the table read so the capture lines up with its data.
        tick_pipe_d    = {tick_pipe_q[LUT_LAT-1:0], adv};
        sample_valid_d = tick_pipe_q[LUT_LAT];
        smp1_d         = tick_pipe_q[LUT_LAT] ? lut_data1 : smp1_q;
        smp2_d         = tick_pipe_q[LUT_LAT] ? lut_data2 : smp2_q;
        smp3_d         = tick_pipe_q[LUT_LAT] ? lut_data3 : smp3_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            ftw_q          <= '0;
            phase_q        <= '0;
            pend_ftw_q     <= '0;
            pend_phase_q   <= '0;
            pend_valid_q   <= 1'b0;
            drain_cnt_q    <= '0;
            tick_pipe_q    <= '0;
            addr1_q        <= '0;
            addr2_q        <= '0;
            addr3_q        <= '0;
            smp1_q         <= '0;
            smp2_q         <= '0;
            smp3_q         <= '0;
            sample_valid_q <= 1'b0;
            wrap_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            ftw_q          <= ftw_d;
            phase_q        <= phase_d;
            pend_ftw_q     <= pend_ftw_d;
            pend_phase_q   <= pend_phase_d;
            pend_valid_q   <= pend_valid_d;
            drain_cnt_q    <= drain_cnt_d;
            tick_pipe_q    <= tick_pipe_d;
            addr1_q        <= addr1_d;
            addr2_q        <= addr2_d;
            addr3_q        <= addr3_d;
            smp1_q         <= smp1_d;
            smp2_q         <= smp2_d;
            smp3_q         <= smp3_d;
            sample_valid_q <= sample_valid_d;
            wrap_q         <= wrap_d;
        end
    end

    assign address1     = addr1_q;
    assign address2     = addr2_q;
    assign address3     = addr3_q;
    assign sample1      = smp1_q;
    assign sample2      = smp2_q;
    assign sample3      = smp3_q;
    assign sample_valid = sample_valid_q;
    assign wrap         = wrap_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Directed bench for sine_phase_sequencer with a one-cycle stub table returning its address.
module tb_sine_phase_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        sample_tick = 1'b0;
    logic [14:0] address1, address2, address3;
    logic [15:0] lut_data1 = '0, lut_data2 = '0, lut_data3 = '0;
    logic [15:0] sample1, sample2, sample3;
    logic        sample_valid, wrap, busy;
    int          checks = 0;
    int          errors = 0;

    sine_phase_sequencer_if cfg_bus ();

    sine_phase_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_tick  (sample_tick),
        .cfg          (cfg_bus),
        .address1     (address1),
        .address2     (address2),
        .address3     (address3),
        .lut_data1    (lut_data1),
        .lut_data2    (lut_data2),
        .lut_data3    (lut_data3),
        .sample1      (sample1),
        .sample2      (sample2),
        .sample3      (sample3),
        .sample_valid (sample_valid),
        .wrap         (wrap),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Stub table: registered read returning the address as data.
    always @(posedge clk) begin
        lut_data1 <= {1'b0, address1};
        lut_data2 <= {1'b0, address2};
        lut_data3 <= {1'b0, address3};
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [31:0] f, input logic [14:0] p);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ftw   = f;
        cfg_bus.cfg_phase = p;
        step();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic go_idle;
        sample_tick = 1'b0;
        enable      = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        step();
        step();
        checks++; if (address1 !== 15'd0) begin errors++; $display("FAIL reset_addr1 got %0d exp 0", address1); end
        checks++; if (address3 !== 15'd0) begin errors++; $display("FAIL reset_addr3 got %0d exp 0", address3); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", sample_valid); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %0b exp 0", wrap); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %0b exp 1", cfg_bus.cfg_ready); end
        rst_n = 1'b1;
        step();
        $display("reset done");
    endtask

    task automatic test_tuning;
        load_cfg(32'h0002_0000, 15'd0);
        enable = 1'b1;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tune_busy got %0b exp 1", busy); end
        sample_tick = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (address1 !== 15'(k)) begin errors++; $display("FAIL tune_addr1 k=%0d got %0d exp %0d", k, address1, k); end
            checks++; if (address2 !== 15'(10923 + k)) begin errors++; $display("FAIL tune_addr2 k=%0d got %0d exp %0d", k, address2, 10923 + k); end
            checks++; if (address3 !== 15'(21845 + k)) begin errors++; $display("FAIL tune_addr3 k=%0d got %0d exp %0d", k, address3, 21845 + k); end
            if (k >= 3) begin
                checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL tune_valid k=%0d got %0b exp 1", k, sample_valid); end
                checks++; if (sample1 !== 16'(k - 2)) begin errors++; $display("FAIL tune_sample1 k=%0d got %0d exp %0d", k, sample1, k - 2); end
                checks++; if (sample2 !== 16'(10921 + k)) begin errors++; $display("FAIL tune_sample2 k=%0d got %0d exp %0d", k, sample2, 10921 + k); end
                checks++; if (sample3 !== 16'(21843 + k)) begin errors++; $display("FAIL tune_sample3 k=%0d got %0d exp %0d", k, sample3, 21843 + k); end
            end else begin
                checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL tune_early_valid k=%0d got %0b exp 0", k, sample_valid); end
            end
            $display("tuning tick %0d addr1=%0d valid=%0b sample1=%0d", k, address1, sample_valid, sample1);
        end
        go_idle();
    endtask

    task automatic test_wrap;
        load_cfg(32'h8000_0000, 15'd0);
        enable = 1'b1;
        step();
        sample_tick = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (wrap !== 1'(k % 2)) begin errors++; $display("FAIL wrap_pulse k=%0d got %0b exp %0d", k, wrap, k % 2); end
            checks++; if (address1 !== ((k % 2) ? 15'd0 : 15'd16384)) begin errors++; $display("FAIL wrap_addr1 k=%0d got %0d", k, address1); end
            $display("wrap tick %0d wrap=%0b addr1=%0d", k, wrap, address1);
        end
        go_idle();
    endtask

    task automatic test_addr_wrap;
        load_cfg(32'h0002_0000, 15'd32767);
        enable = 1'b1;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        checks++; if (address1 !== 15'd0) begin errors++; $display("FAIL awrap_addr1 got %0d exp 0", address1); end
        checks++; if (address2 !== 15'd10923) begin errors++; $display("FAIL awrap_addr2 got %0d exp 10923", address2); end
        checks++; if (address3 !== 15'd21845) begin errors++; $display("FAIL awrap_addr3 got %0d exp 21845", address3); end
        $display("addr wrap %0d %0d %0d", address1, address2, address3);
        go_idle();
    endtask

    task automatic test_deferred_cfg;
        load_cfg(32'h4000_0000, 15'd0);
        enable = 1'b1;
        step();
        sample_tick = 1'b1;
        step();
        checks++; if (address1 !== 15'd8192) begin errors++; $display("FAIL defer_e0_addr got %0d exp 8192", address1); end
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ftw   = 32'h2000_0000;
        cfg_bus.cfg_phase = 15'd0;
        step();
        cfg_bus.cfg_valid = 1'b0;
        checks++; if (cfg_bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL defer_ready_drop got %0b exp 0", cfg_bus.cfg_ready); end
        checks++; if (address1 !== 15'd16384) begin errors++; $display("FAIL defer_e1_addr got %0d exp 16384", address1); end
        step();
        checks++; if (address1 !== 15'd24576) begin errors++; $display("FAIL defer_e2_addr got %0d exp 24576", address1); end
        checks++; if (cfg_bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL defer_ready_hold got %0b exp 0", cfg_bus.cfg_ready); end
        step();
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL defer_wrap got %0b exp 1", wrap); end
        checks++; if (address1 !== 15'd0) begin errors++; $display("FAIL defer_e3_addr got %0d exp 0", address1); end
        checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL defer_ready_back got %0b exp 1", cfg_bus.cfg_ready); end
        step();
        checks++; if (address1 !== 15'd4096) begin errors++; $display("FAIL defer_e4_addr got %0d exp 4096", address1); end
        step();
        checks++; if (address1 !== 15'd8192) begin errors++; $display("FAIL defer_e5_addr got %0d exp 8192", address1); end
        $display("deferred cfg applied addr1=%0d", address1);
        go_idle();
    endtask

    task automatic test_drain;
        int valids;
        valids = 0;
        load_cfg(32'h0002_0000, 15'd0);
        enable = 1'b1;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        enable      = 1'b0;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_e1 got %0b exp 1", busy); end
        valids += int'(sample_valid);
        step();
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL drain_valid got %0b exp 1", sample_valid); end
        checks++; if (sample1 !== 16'd1) begin errors++; $display("FAIL drain_sample1 got %0d exp 1", sample1); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_e2 got %0b exp 1", busy); end
        valids += int'(sample_valid);
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy_fall got %0b exp 0", busy); end
        valids += int'(sample_valid);
        repeat (2) begin
            step();
            valids += int'(sample_valid);
        end
        checks++; if (valids != 1) begin errors++; $display("FAIL drain_valid_count got %0d exp 1", valids); end
        enable = 1'b1;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        checks++; if (address1 !== 15'd1) begin errors++; $display("FAIL drain_acc_cleared got %0d exp 1", address1); end
        $display("drain valids=%0d restart addr1=%0d", valids, address1);
        go_idle();
    endtask

    task automatic test_reset_midrun;
        load_cfg(32'h0002_0000, 15'd0);
        enable = 1'b1;
        step();
        sample_tick = 1'b1;
        step();
        step();
        sample_tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (address1 !== 15'd0) begin errors++; $display("FAIL midrst_addr1 got %0d exp 0", address1); end
        checks++; if (sample1 !== 16'd0) begin errors++; $display("FAIL midrst_sample1 got %0d exp 0", sample1); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b exp 0", sample_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b exp 0", busy); end
        checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %0b exp 1", cfg_bus.cfg_ready); end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_valid k=%0d got %0b exp 0", k, sample_valid); end
        end
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        checks++; if (address2 !== 15'd10923) begin errors++; $display("FAIL midrst_cfg_cleared got %0d exp 10923", address2); end
        step();
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_early got %0b exp 0", sample_valid); end
        step();
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL midrst_valid_after got %0b exp 1", sample_valid); end
        $display("reset mid-run recovered valid=%0b", sample_valid);
        go_idle();
    endtask

    initial begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ftw   = '0;
        cfg_bus.cfg_phase = '0;
        test_reset();
        test_tuning();
        test_wrap();
        test_addr_wrap();
        test_deferred_cfg();
        test_drain();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
